// File: rtl/text_periph_pkg.sv
// Shared constants, register map and UART state encoding for the text_periph peripheral.
package text_periph_pkg;

    localparam logic [3:0] OFS_DATA   = 4'h0;
    localparam logic [3:0] OFS_STATUS = 4'h1;
    localparam logic [3:0] OFS_DIV    = 4'h2;
    localparam logic [3:0] OFS_IRQEN  = 4'h3;

    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_RX_NONEMPTY = 2;
    localparam int ST_RX_FULL     = 3;
    localparam int ST_TX_OVF      = 4;
    localparam int ST_RX_OVF      = 5;
    localparam int ST_TX_BUSY     = 6;
    localparam int ST_FRAME_ERR   = 7;

    localparam logic [15:0] DIV_MIN = 16'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        return (div < DIV_MIN) ? DIV_MIN : div;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous 8-bit FIFO; a push to a full FIFO is accepted only when a pop happens in the same cycle.
module uart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     i_cpu_clk,
    input  logic                     i_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wr_data,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge i_cpu_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers are exactly log2(DEPTH) wide so they wrap naturally.
    always_ff @(posedge i_cpu_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/text_periph.sv
// Memory-mapped 8N1 UART text peripheral. Define TEXT_PERIPH_RX_EN to build the receive path
// (synchroniser, RX FSM, RX FIFO); without it the block is transmit-only.
module text_periph
    import text_periph_pkg::*;
#(
    parameter int               DATA_W        = 32,
    parameter logic [DATA_W-1:0] BASE_ADDR    = 32'hFFFF_FF00,
    parameter int               FIFO_DEPTH    = 16,
    parameter logic [15:0]      CLK_DIV_RESET = 16'd216
) (
    input  logic              i_rst,
    input  logic              i_cpu_clk,
    input  logic              i_bus_clk,
    input  logic              i_bus_we,
    input  logic [DATA_W-1:0] i_bus_addr,
    input  logic [DATA_W-1:0] i_bus_data,
    output logic [DATA_W-1:0] o_bus_data,
    output logic              o_bus_data_ready,
    output logic              o_uart_tx,
    input  logic              i_uart_rx,
    output logic              o_irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              bus_clk_q;
    logic              hit;
    logic              wr;
    logic              rd;
    logic [3:0]        ofs;
    logic [15:0]       divisor;
    logic [1:0]        irq_en;
    logic              tx_ovf;
    logic [7:0]        status;
    logic [15:0]       read_val;

    logic              tx_push_req;
    logic              tx_pop;
    logic [7:0]        tx_head;
    logic              tx_full;
    logic              tx_empty;
    logic [CNT_W-1:0]  tx_count;

    uart_state_t       tx_state, tx_state_n;
    logic [15:0]       tx_cnt, tx_cnt_n;
    logic [15:0]       tx_div, tx_div_n;
    logic [2:0]        tx_bit, tx_bit_n;
    logic [7:0]        tx_shreg, tx_shreg_n;
    logic              tx_line, tx_line_n;
    logic              tx_bit_end;
    logic              tx_load;
    logic              tx_busy;

    logic              rx_nonempty;
    logic              rx_full;
    logic              rx_ovf;
    logic              frame_err;
    logic [7:0]        rx_data;
    logic              unused_ok;

    assign ofs         = i_bus_addr[3:0];
    assign hit         = i_bus_clk & ~bus_clk_q
                       & (i_bus_addr[DATA_W-1:4] == BASE_ADDR[DATA_W-1:4]);
    assign wr          = hit & i_bus_we;
    assign rd          = hit & ~i_bus_we;
    assign tx_push_req = wr & (ofs == OFS_DATA);
    assign tx_busy     = (tx_state != IDLE);
    assign o_uart_tx   = tx_line;

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_cpu_clk (i_cpu_clk),
        .i_rst     (i_rst),
        .push      (tx_push_req),
        .pop       (tx_pop),
        .wr_data   (i_bus_data[7:0]),
        .rd_data   (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    always_comb begin
        status                 = '0;
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_RX_NONEMPTY] = rx_nonempty;
        status[ST_RX_FULL]     = rx_full;
        status[ST_TX_OVF]      = tx_ovf;
        status[ST_RX_OVF]      = rx_ovf;
        status[ST_TX_BUSY]     = tx_busy;
        status[ST_FRAME_ERR]   = frame_err;
    end

    always_comb begin
        read_val = '0;
        case (ofs)
            OFS_DATA:   read_val = {8'h00, rx_data};
            OFS_STATUS: read_val = {8'h00, status};
            OFS_DIV:    read_val = divisor;
            OFS_IRQEN:  read_val = {14'd0, irq_en};
            default:    read_val = '0;
        endcase
    end

    // Bus response, control registers and the TX overflow sticky bit; a set wins over a clear.
    always_ff @(posedge i_cpu_clk or posedge i_rst) begin
        if (i_rst) begin
            bus_clk_q        <= 1'b0;
            o_bus_data_ready <= 1'b0;
            o_bus_data       <= '0;
            divisor          <= CLK_DIV_RESET;
            irq_en           <= '0;
            tx_ovf           <= 1'b0;
            o_irq            <= 1'b0;
        end else begin
            bus_clk_q        <= i_bus_clk;
            o_bus_data_ready <= hit;
            if (rd) begin
                o_bus_data <= DATA_W'(read_val);
            end
            if (wr && ofs == OFS_DIV) begin
                divisor <= clamp_div(i_bus_data[15:0]);
            end
            if (wr && ofs == OFS_IRQEN) begin
                irq_en <= i_bus_data[1:0];
            end
            if (wr && ofs == OFS_STATUS && i_bus_data[ST_TX_OVF]) begin
                tx_ovf <= 1'b0;
            end
            if (tx_push_req && tx_full && !tx_pop) begin
                tx_ovf <= 1'b1;
            end
            o_irq <= (irq_en[0] & rx_nonempty) | (irq_en[1] & tx_empty & ~tx_busy);
        end
    end

    assign tx_bit_end = (tx_cnt == tx_div);
    assign tx_load    = ~tx_empty & ((tx_state == IDLE) | ((tx_state == STOP) & tx_bit_end));

    always_ff @(posedge i_cpu_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_div   <= tx_div_n;
            tx_bit   <= tx_bit_n;
            tx_shreg <= tx_shreg_n;
            tx_line  <= tx_line_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 16'd1;
        tx_div_n   = tx_div;
        tx_bit_n   = tx_bit;
        tx_shreg_n = tx_shreg;
        case (tx_state)
            IDLE: begin
                tx_cnt_n = '0;
                if (tx_load) begin
                    tx_state_n = START;
                    tx_shreg_n = tx_head;
                    tx_div_n   = divisor;
                end
            end
            START: begin
                if (tx_bit_end) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = DATA;
                end
            end
            DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = STOP;
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shreg_n = {1'b0, tx_shreg[7:1]};
                    end
                end
            end
            STOP: begin
                if (tx_bit_end) begin
                    tx_cnt_n = '0;
                    if (tx_load) begin
                        tx_state_n = START;
                        tx_shreg_n = tx_head;
                        tx_div_n   = divisor;
                    end else begin
                        tx_state_n = IDLE;
                    end
                end
            end
            default: tx_state_n = IDLE;
        endcase
    end

    // The line is registered from the next state so it changes in step with the FSM and never glitches.
    always_comb begin
        tx_pop = tx_load;
        case (tx_state_n)
            START:   tx_line_n = 1'b0;
            DATA:    tx_line_n = tx_shreg_n[0];
            default: tx_line_n = 1'b1;
        endcase
    end

`ifdef TEXT_PERIPH_RX_EN
    logic              rx_meta;
    logic              rx_sync;
    logic              rx_prev;
    logic              rx_pop;
    logic              rx_push;
    logic              frame_set;
    logic [7:0]        rx_head;
    logic              rx_empty;
    logic [CNT_W-1:0]  rx_count;
    logic              rx_sample;
    logic [16:0]       rx_div_p1;

    uart_state_t       rx_state, rx_state_n;
    logic [15:0]       rx_cnt, rx_cnt_n;
    logic [15:0]       rx_div, rx_div_n;
    logic [2:0]        rx_bit, rx_bit_n;
    logic [7:0]        rx_shreg, rx_shreg_n;

    assign rx_pop      = rd & (ofs == OFS_DATA);
    assign rx_nonempty = ~rx_empty;
    assign rx_data     = rx_empty ? 8'h00 : rx_head;
    assign rx_div_p1   = {1'b0, rx_div} + 17'd1;
    assign rx_sample   = (rx_state == START) ? (rx_cnt == rx_div_p1[16:1]) : (rx_cnt == rx_div);
    assign unused_ok   = ^{tx_count, rx_count, i_bus_data[DATA_W-1:16]};

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_cpu_clk (i_cpu_clk),
        .i_rst     (i_rst),
        .push      (rx_push),
        .pop       (rx_pop),
        .wr_data   (rx_shreg),
        .rd_data   (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    always_ff @(posedge i_cpu_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            rx_state  <= IDLE;
            rx_cnt    <= '0;
            rx_div    <= '0;
            rx_bit    <= '0;
            rx_shreg  <= '0;
            rx_ovf    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta  <= i_uart_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_div   <= rx_div_n;
            rx_bit   <= rx_bit_n;
            rx_shreg <= rx_shreg_n;
            if (wr && ofs == OFS_STATUS && i_bus_data[ST_RX_OVF]) begin
                rx_ovf <= 1'b0;
            end
            if (wr && ofs == OFS_STATUS && i_bus_data[ST_FRAME_ERR]) begin
                frame_err <= 1'b0;
            end
            if (rx_push && rx_full && !rx_pop) begin
                rx_ovf <= 1'b1;
            end
            if (frame_set) begin
                frame_err <= 1'b1;
            end
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 16'd1;
        rx_div_n   = rx_div;
        rx_bit_n   = rx_bit;
        rx_shreg_n = rx_shreg;
        case (rx_state)
            IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_sync) begin
                    rx_state_n = START;
                    rx_div_n   = divisor;
                end
            end
            START: begin
                if (rx_sample) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_sample) begin
                    rx_cnt_n   = '0;
                    rx_shreg_n = {rx_sync, rx_shreg[7:1]};
                    if (rx_bit == 3'd7) begin
                        rx_state_n = STOP;
                    end else begin
                        rx_bit_n = rx_bit + 3'd1;
                    end
                end
            end
            STOP: begin
                if (rx_sample) begin
                    rx_cnt_n   = '0;
                    rx_state_n = IDLE;
                end
            end
            default: rx_state_n = IDLE;
        endcase
    end

    always_comb begin
        rx_push   = (rx_state == STOP) & rx_sample & rx_sync;
        frame_set = (rx_state == STOP) & rx_sample & ~rx_sync;
    end
`else
    assign rx_nonempty = 1'b0;
    assign rx_full     = 1'b0;
    assign rx_ovf      = 1'b0;
    assign frame_err   = 1'b0;
    assign rx_data     = 8'h00;
    assign unused_ok   = ^{tx_count, i_uart_rx, i_bus_data[DATA_W-1:16],
                           i_bus_data[ST_RX_OVF], i_bus_data[ST_FRAME_ERR]};
`endif

endmodule

// File: tb/tb_text_periph.sv
// Scoreboard bench for text_periph: bus reads/writes, TX framing and overflow, reset,
// and the receive path (expected values follow whether TEXT_PERIPH_RX_EN is defined).
module tb_text_periph;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
`ifdef TEXT_PERIPH_RX_EN
    localparam bit RX_ON = 1'b1;
`else
    localparam bit RX_ON = 1'b0;
`endif

    logic        rst = 1'b1;
    logic        cpu_clk = 1'b0;
    logic        bus_clk = 1'b0;
    logic        bus_we = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        uart_tx;
    logic        uart_rx = 1'b1;
    logic        irq;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] exp_last = '0;

    text_periph dut (
        .i_rst            (rst),
        .i_cpu_clk        (cpu_clk),
        .i_bus_clk        (bus_clk),
        .i_bus_we         (bus_we),
        .i_bus_addr       (bus_addr),
        .i_bus_data       (bus_wdata),
        .o_bus_data       (bus_rdata),
        .o_bus_data_ready (bus_ready),
        .o_uart_tx        (uart_tx),
        .i_uart_rx        (uart_rx),
        .o_irq            (irq)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Every ready pulse consumes one scoreboard entry; o_bus_data must match it.
    always @(negedge cpu_clk) begin
        if (!rst && bus_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_ready: got ready=1 required no pending transaction");
            end else begin
                logic [31:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checkOutput(n, bus_rdata, e);
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic hit, input logic [31:0] rd_exp, input string name);
        if (hit) begin
            if (!we) exp_last = rd_exp;
            exp_q.push_back(exp_last);
            name_q.push_back(name);
        end
        @(negedge cpu_clk);
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wdata;
        bus_clk   = 1'b1;
        @(negedge cpu_clk);
        checkOutput({name, "_ready"}, {31'd0, bus_ready}, {31'd0, hit});
        bus_clk = 1'b0;
        @(negedge cpu_clk);
        checkOutput({name, "_ready_pulse"}, {31'd0, bus_ready}, 32'd0);
    endtask

    task automatic bus_write(input logic [3:0] ofs, input logic [31:0] data, input string name);
        applyStimulus(1'b1, BASE + {28'd0, ofs}, data, 1'b1, 32'd0, name);
    endtask

    task automatic bus_read(input logic [3:0] ofs, input logic [31:0] exp, input string name);
        applyStimulus(1'b0, BASE + {28'd0, ofs}, 32'd0, 1'b1, exp, name);
    endtask

    // Drives one frame at 8 cycles per bit (divisor 7).
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge cpu_clk);
            uart_rx = bits[i];
            repeat (7) @(negedge cpu_clk);
        end
        @(negedge cpu_clk);
        uart_rx = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0] frame;

        repeat (3) @(negedge cpu_clk);
        checkOutput("rst_rdata", bus_rdata, 32'd0);
        checkOutput("rst_ready", {31'd0, bus_ready}, 32'd0);
        checkOutput("rst_tx", {31'd0, uart_tx}, 32'd1);
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;

        bus_read(4'h1, 32'h02, "status_reset");
        bus_read(4'h2, 32'hD8, "div_reset");

        applyStimulus(1'b0, BASE + 32'h10, 32'd0, 1'b0, 32'd0, "miss_read");
        applyStimulus(1'b1, BASE + 32'h12, 32'd5, 1'b0, 32'd0, "miss_write");
        bus_read(4'h2, 32'hD8, "div_after_miss");
        bus_read(4'h5, 32'h00, "ofs5_read");
        bus_write(4'h7, 32'hFF, "ofs7_write");
        bus_write(4'h2, 32'd1, "div_clamp_wr");
        bus_read(4'h2, 32'd3, "div_clamp");

        bus_write(4'h3, 32'h2, "irqen_tx");
        checkOutput("irq_tx_idle", {31'd0, irq}, 32'd1);
        bus_read(4'h3, 32'h2, "irqen_read");
        bus_write(4'h3, 32'h0, "irqen_off");
        checkOutput("irq_off", {31'd0, irq}, 32'd0);

        bus_write(4'h2, 32'd3, "div3");
        bus_write(4'h0, 32'h55, "tx_55");
        frame = 10'b1_0101_0101_0;
        for (int i = 0; i < 40; i++) begin
            checkOutput($sformatf("tx55_cycle%0d", i), {31'd0, uart_tx}, {31'd0, frame[i/4]});
            @(negedge cpu_clk);
        end
        bus_read(4'h1, 32'h02, "status_after_tx");

        bus_write(4'h2, 32'd7, "div7");
        for (int k = 0; k < 17; k++) bus_write(4'h0, 32'h00, $sformatf("fill%0d", k));
        bus_read(4'h1, 32'h41, "status_full");
        bus_write(4'h0, 32'h00, "data_drop");
        bus_read(4'h1, 32'h51, "status_tx_ovf");
        bus_write(4'h1, 32'h10, "clear_tx_ovf");
        bus_read(4'h1, 32'h41, "status_ovf_clr");
        checkOutput("tx_mid_frame", {31'd0, uart_tx}, 32'd0);

        rst = 1'b1;
        #1;
        checkOutput("rst_mid_tx", {31'd0, uart_tx}, 32'd1);
        checkOutput("rst_mid_rdata", bus_rdata, 32'd0);
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        rst = 1'b0;
        exp_last = '0;
        bus_read(4'h1, 32'h02, "status_after_rst");
        checkOutput("tx_after_rst", {31'd0, uart_tx}, 32'd1);
        bus_read(4'h2, 32'hD8, "div_after_rst");

        bus_write(4'h2, 32'd7, "div7_rx");
        send_rx(8'hA5, 1'b1);
        repeat (12) @(negedge cpu_clk);
        bus_read(4'h1, RX_ON ? 32'h06 : 32'h02, "status_rx");
        bus_read(4'h0, RX_ON ? 32'hA5 : 32'h00, "rx_data");
        bus_read(4'h0, 32'h00, "rx_data_empty");

        send_rx(8'h3C, 1'b0);
        repeat (12) @(negedge cpu_clk);
        bus_read(4'h1, RX_ON ? 32'h82 : 32'h02, "status_frame_err");
        bus_read(4'h0, 32'h00, "rx_data_fe");

        @(negedge cpu_clk);
        uart_rx = 1'b0;
        repeat (2) @(negedge cpu_clk);
        uart_rx = 1'b1;
        repeat (100) @(negedge cpu_clk);
        bus_read(4'h1, RX_ON ? 32'h82 : 32'h02, "status_glitch");
        bus_read(4'h0, 32'h00, "rx_data_glitch");
        bus_write(4'h1, 32'h80, "clear_fe");
        bus_read(4'h1, 32'h02, "status_fe_clr");

        bus_write(4'h3, 32'h1, "irqen_rx");
        send_rx(8'h5A, 1'b1);
        repeat (12) @(negedge cpu_clk);
        checkOutput("irq_rx", {31'd0, irq}, {31'd0, RX_ON});
        bus_read(4'h0, RX_ON ? 32'h5A : 32'h00, "rx_data_5a");
        @(negedge cpu_clk);
        checkOutput("irq_rx_clear", {31'd0, irq}, 32'd0);

        repeat (4) @(negedge cpu_clk);
        checkOutput("sb_drain", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
